// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes stage feeding ShiftRows.
// A 128-bit state is accepted over valid/ready, substituted LANES bytes per
// cycle through LANES forward S-box lookups, then held on out_data until the
// downstream round logic takes it. Byte 0 is s[127:120], column-major.
// Optional build macro: SUB_BYTES_STALL_CNT_EN enables the saturating
// output back-pressure counter on stall_cnt (tied to zero otherwise).
module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [15:0]  stall_cnt
);

  localparam int NCHUNK  = 16 / LANES;
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CHUNK_W = 8 * LANES;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  // Only divisors of 16 give a whole number of chunks per block.
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 forward S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt_p0;
  logic [127:0]       data_p0;
  logic [127:0]       data_next;
  logic [CHUNK_W-1:0] chunk_in;
  logic [CHUNK_W-1:0] chunk_out;

  // Chunk k occupies bytes k*LANES .. k*LANES+LANES-1, byte 0 at the MSB end.
  assign chunk_in = data_p0[127 - CHUNK_W * int'(cnt_p0) -: CHUNK_W];

  genvar j;
  generate
    for (j = 0; j < LANES; j++) begin : g_lane
      assign chunk_out[CHUNK_W - 1 - 8 * j -: 8] = sbox(chunk_in[CHUNK_W - 1 - 8 * j -: 8]);
    end
  endgenerate

  // Splice the substituted chunk back into the working state.
  always_comb begin
    data_next = data_p0;
    data_next[127 - CHUNK_W * int'(cnt_p0) -: CHUNK_W] = chunk_out;
  end

  // Control FSM; in_ready/out_valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_p0    <= '0;
      data_p0   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_p0  <= in_data;
            cnt_p0   <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          data_p0 <= data_next;
          if (cnt_p0 == LAST_CHUNK) begin
            cnt_p0    <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          cnt_p0    <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // The result is the working register itself; only out_valid qualifies it.
  assign out_data = data_p0;

`ifdef SUB_BYTES_STALL_CNT_EN
  logic [15:0] stall_p0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count cycles where a finished result waits on downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_p0 <= 16'h0000;
    end else if (state == DONE && !out_ready) begin
      stall_p0 <= sat_inc(stall_p0);
    end
  end

  assign stall_cnt = stall_p0;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Iterative AES SubBytes stage. Sits directly upstream of the combinational ShiftRows stage in the encrypt round datapath.
- Accepts a 128-bit state over a valid/ready handshake. Substitutes LANES bytes per cycle through LANES forward S-box instances.
- Presents the substituted 128-bit state on a valid/ready output whose data feeds ShiftRows unchanged.
- Byte order: s[127:120] is state byte 0 (row 0, col 0), column-major, matching ShiftRows.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error.
- NCHUNK, 16/LANES, derived local parameter; cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a state word
- in_ready  output  1  block can accept a state word
- in_data  input  128  state before SubBytes
- out_valid  output  1  substituted state available
- out_ready  input  1  downstream (ShiftRows/round register) accepts
- out_data  output  128  state after SubBytes, to ShiftRows input s
- stall_cnt  output  16  output back-pressure cycle count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, data reg=0, chunk counter=0, out_valid=0, in_ready=1 after release, out_data=0, stall_cnt=0.
- FSM IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: load in_data into data reg, counter=0, go to BUSY.
- FSM BUSY: in_ready=0, out_valid=0.
  - Each cycle, replace chunk k = counter with its S-box image. Chunk k is bits [127-8*LANES*k -: 8*LANES].
  - Counter increments each cycle. When counter==NCHUNK-1, go to DONE and clear the counter.
- FSM DONE: out_valid=1, out_data=data reg, in_ready=0.
  - On out_ready: go to IDLE.
  - out_data and out_valid stay stable while out_ready=0.
- Latency: the handshake edge at cycle t gives out_valid=1 from cycle t+NCHUNK+1. With LANES=4, that is 5 cycles after acceptance.
- Throughput: one block per NCHUNK+2 cycles with out_ready held high. No overlap between blocks; in_ready is asserted only in IDLE.
- out_data is registered only: no combinational path from in_data or out_ready to out_data.
- in_data is sampled only at acceptance. Changes to in_data during BUSY/DONE have no effect.
- in_valid dropping without a handshake is legal; nothing is loaded.
- S-box: standard FIPS-197 forward table, 256 entries, combinational, byte-exact. LANES identical instances.
- Reset mid-operation: the block is aborted, all state clears, and no partial result is ever presented.
- out_ready held high in IDLE/BUSY has no effect.

Optional Feature:
- Macro: SUB_BYTES_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with state==DONE && out_ready==0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: stall_cnt is tied to 16'h0000 and no counter flops are inferred.
- All other behaviour is identical in both builds.

Test Plan:
- FIPS-197 App. B, LANES=4: in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> out_data=d42711aee0bf98f1b8b45de51e415230, out_valid rising 5 cycles after acceptance.
- All-zero and all-FF, run once each for LANES=1, 4 and 16: in 0x00..00 -> out 0x6363..63; in 0xFF..FF -> out 0x1616..16. Latency must be 17, 5 and 2 cycles respectively.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE. Required: out_data stable, in_ready=0 throughout, in_valid pulses ignored. With the macro defined, stall_cnt=10 after release.
- Byte placement: in_data with only byte 5 = 0x53 and all others 0x00 -> out byte 5 (bits [87:80]) = 0xED, all others 0x63.
- Reset mid-BUSY: assert rst_n=0 at counter==1. Required: out_valid=0 and in_ready=1 immediately after release, out_data=0. Then a new block (0x01 repeated) -> 0x7C repeated.
- Back-to-back: in_valid and out_ready held high, 3 blocks. Required: acceptances spaced NCHUNK+2 cycles apart, results in order, no dropped or duplicated block.
